// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM with unified-memory handshake.
// Optional bne support is enabled by defining MIPS_BNE_EN.
module mips_multicycle_controller (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        BNEBR    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    state_t     state;
    logic [1:0] alu_op;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_en;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (MemReady) state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYP:      state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEXEC;
                        OP_J:         state <= JUMP;
`ifdef MIPS_BNE_EN
                        OP_BNE:       state <= BNEBR;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (Op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (MemReady) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (MemReady) state <= FETCH;
                EXECUTE:  state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                ADDIEXEC: state <= ADDIWB;
                ADDIWB:   state <= FETCH;
                JUMP:     state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        IorD      = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        reg_write = 1'b0;
        ALUSrcA   = 1'b0;
        pc_en     = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        alu_op    = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = MemReady;
                pc_en    = MemReady;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                pc_en   = Zero;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:   reg_write = 1'b1;
            JUMP: begin
                PCSrc = 2'b10;
                pc_en = 1'b1;
            end
`ifdef MIPS_BNE_EN
            BNEBR: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                pc_en   = ~Zero;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b00:   ALUControl = 3'b010;
            2'b01:   ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    // Enables are killed during reset even though FETCH would follow MemReady
    assign IRWrite  = ir_write & Reset;
    assign MemWrite = mem_write & Reset;
    assign RegWrite = reg_write & Reset;
    assign PCEn     = pc_en & Reset;
    assign State    = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed-vector bench for the multicycle MIPS controller.
module tb_mips_multicycle_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int checks = 0;
    int failures = 0;

    mips_multicycle_controller dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct),
        .Zero(Zero), .MemReady(MemReady), .IorD(IorD),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCEn(PCEn), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .State(State)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0; MemReady = 1'b1; Op = 6'b100011;
        tick; tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
        checks++; if ({IRWrite, PCEn, MemWrite, RegWrite} !== 4'b0000) begin
            failures++; $display("FAIL reset_enables got=%b exp=0000", {IRWrite, PCEn, MemWrite, RegWrite}); end
        Reset = 1'b1; #1;
        checks++; if ({IRWrite, PCEn} !== 2'b11) begin failures++; $display("FAIL release_fetch_en got=%b exp=11", {IRWrite, PCEn}); end
        checks++; if ({IorD, ALUSrcA, ALUSrcB, PCSrc, ALUControl} !== 9'b0_0_01_00_010) begin
            failures++; $display("FAIL fetch_selects got=%b exp=001000010", {IorD, ALUSrcA, ALUSrcB, PCSrc, ALUControl}); end
        Op = 6'b111111;
        tick;
        checks++; if (State !== 4'd1) begin failures++; $display("FAIL release_to_decode got=%0d exp=1", State); end
        checks++; if ({IRWrite, PCEn, ALUSrcB} !== 4'b0011) begin
            failures++; $display("FAIL decode_outputs got=%b exp=0011", {IRWrite, PCEn, ALUSrcB}); end
        tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL unknown_op_to_fetch got=%0d exp=0", State); end
    endtask

    task automatic test_fetch_wait;
        MemReady = 1'b0; Op = 6'b100011; #1;
        checks++; if ({IRWrite, PCEn} !== 2'b00) begin failures++; $display("FAIL fetch_wait_en got=%b exp=00", {IRWrite, PCEn}); end
        tick; tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL fetch_wait_hold got=%0d exp=0", State); end
    endtask

    task automatic test_lw;
        int exp_s[6] = '{0, 1, 2, 3, 4, 0};
        Op = 6'b100011; MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (State !== exp_s[i][3:0]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, State, exp_s[i]); end
            checks++; if ({RegWrite, MemtoReg} !== {2{exp_s[i] == 4}}) begin
                failures++; $display("FAIL lw_wb[%0d] got=%b exp=%b", i, {RegWrite, MemtoReg}, {2{exp_s[i] == 4}}); end
            checks++; if ({IorD, ALUSrcA} !== {exp_s[i] == 3, exp_s[i] == 2}) begin
                failures++; $display("FAIL lw_sel[%0d] got=%b", i, {IorD, ALUSrcA}); end
            if (i < 5) tick;
        end
    endtask

    task automatic test_sw;
        int mw = 0;
        Op = 6'b101011; MemReady = 1'b1;
        tick; tick; tick;
        checks++; if (State !== 4'd5) begin failures++; $display("FAIL sw_state got=%0d exp=5", State); end
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3); #1;
            if (MemWrite === 1'b1 && IorD === 1'b1 && State === 4'd5) mw++;
            tick;
        end
        checks++; if (mw !== 4) begin failures++; $display("FAIL sw_memwrite_cycles got=%0d exp=4", mw); end
        checks++; if (State !== 4'd0 || MemWrite !== 1'b0) begin
            failures++; $display("FAIL sw_done got=%0d/%b exp=0/0", State, MemWrite); end
    endtask

    task automatic test_rtype;
        logic [5:0] f[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
        logic [2:0] e[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};
        Op = 6'b000000; Funct = 6'b101010; MemReady = 1'b1;
        tick; tick;
        checks++; if (State !== 4'd6) begin failures++; $display("FAIL rt_state got=%0d exp=6", State); end
        checks++; if (ALUControl !== 3'b111) begin failures++; $display("FAIL rt_slt got=%b exp=111", ALUControl); end
        checks++; if ({ALUSrcA, ALUSrcB} !== 3'b100) begin failures++; $display("FAIL rt_srcs got=%b exp=100", {ALUSrcA, ALUSrcB}); end
        for (int i = 0; i < 5; i++) begin
            Funct = f[i]; #1;
            checks++; if (ALUControl !== e[i]) begin failures++; $display("FAIL rt_funct[%0d] got=%b exp=%b", i, ALUControl, e[i]); end
        end
        Funct = 6'b101010;
        tick;
        checks++; if (State !== 4'd7) begin failures++; $display("FAIL aluwb_state got=%0d exp=7", State); end
        checks++; if ({RegWrite, RegDst, MemtoReg} !== 3'b110) begin
            failures++; $display("FAIL aluwb_out got=%b exp=110", {RegWrite, RegDst, MemtoReg}); end
        checks++; if (ALUControl !== 3'b010) begin failures++; $display("FAIL aluwb_aluctl got=%b exp=010", ALUControl); end
        tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL rt_end got=%0d exp=0", State); end
    endtask

    task automatic test_beq;
        Op = 6'b000100; Zero = 1'b1; MemReady = 1'b1;
        tick; tick;
        checks++; if (State !== 4'd8) begin failures++; $display("FAIL beq_state got=%0d exp=8", State); end
        checks++; if ({PCEn, PCSrc, ALUControl} !== 6'b1_01_110) begin
            failures++; $display("FAIL beq_taken got=%b exp=101110", {PCEn, PCSrc, ALUControl}); end
        Zero = 1'b0; #1;
        checks++; if (PCEn !== 1'b0) begin failures++; $display("FAIL beq_not_taken got=%b exp=0", PCEn); end
        tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL beq_end got=%0d exp=0", State); end
    endtask

    task automatic test_addi_jump;
        Op = 6'b001000; MemReady = 1'b1;
        tick; tick;
        checks++; if (State !== 4'd9 || {ALUSrcA, ALUSrcB, RegWrite} !== 4'b1100) begin
            failures++; $display("FAIL addi_exec got=%0d/%b exp=9/1100", State, {ALUSrcA, ALUSrcB, RegWrite}); end
        tick;
        checks++; if (State !== 4'd10 || {RegWrite, RegDst, MemtoReg} !== 3'b100) begin
            failures++; $display("FAIL addi_wb got=%0d/%b exp=10/100", State, {RegWrite, RegDst, MemtoReg}); end
        tick;
        Op = 6'b000010;
        tick; tick;
        checks++; if (State !== 4'd11 || {PCEn, PCSrc} !== 3'b110) begin
            failures++; $display("FAIL jump got=%0d/%b exp=11/110", State, {PCEn, PCSrc}); end
        tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL jump_end got=%0d exp=0", State); end
    endtask

    task automatic test_bne;
        Op = 6'b000101; Zero = 1'b1; MemReady = 1'b1;
        tick;
        checks++; if (State !== 4'd1 || PCEn !== 1'b0) begin
            failures++; $display("FAIL bne_decode got=%0d/%b exp=1/0", State, PCEn); end
        tick;
`ifdef MIPS_BNE_EN
        checks++; if (State !== 4'd12 || {PCEn, PCSrc} !== 3'b001) begin
            failures++; $display("FAIL bne_eq got=%0d/%b exp=12/001", State, {PCEn, PCSrc}); end
        Zero = 1'b0; #1;
        checks++; if (PCEn !== 1'b1) begin failures++; $display("FAIL bne_ne got=%b exp=1", PCEn); end
        tick;
`endif
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL bne_end got=%0d exp=0", State); end
    endtask

    task automatic test_reset_midmem;
        int rw = 0;
        Op = 6'b100011; MemReady = 1'b1;
        tick; tick; tick;
        MemReady = 1'b0;
        checks++; if (State !== 4'd3) begin failures++; $display("FAIL midmem_state got=%0d exp=3", State); end
        for (int i = 0; i < 2; i++) begin
            #1; if (RegWrite !== 1'b0) rw++;
            tick;
        end
        Reset = 1'b0; #1;
        if (RegWrite !== 1'b0) rw++;
        tick;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL midmem_reset got=%0d exp=0", State); end
        MemReady = 1'b1; #1;
        if (RegWrite !== 1'b0) rw++;
        checks++; if ({IRWrite, PCEn} !== 2'b00) begin failures++; $display("FAIL reset_gate got=%b exp=00", {IRWrite, PCEn}); end
        tick;
        MemReady = 1'b0; Reset = 1'b1; #1;
        if (RegWrite !== 1'b0) rw++;
        tick;
        checks++; if (rw !== 0 || State !== 4'd0) begin
            failures++; $display("FAIL midmem_regwrite got=%0d/%0d exp=0/0", rw, State); end
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi_jump();
        test_bne();
        test_reset_midmem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
